// File: rtl/tour_cmd.sv
`default_nettype none
// ============================================================================
// tour_cmd : knight-tour move sequencer and UART/tour command mux   rev 1.0
// ============================================================================
module tour_cmd #(
  parameter int         NUM_MOVES  = 24,
  parameter logic [3:0] OP_MOVE    = 4'h2,
  parameter logic [3:0] OP_FANFARE = 4'h3,
  parameter logic [7:0] RESP_MID   = 8'h5A,
  parameter logic [7:0] RESP_DONE  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);
  localparam logic [7:0] HEAD_N    = 8'h00;
  localparam logic [7:0] HEAD_W    = 8'h3F;
  localparam logic [7:0] HEAD_S    = 8'h7F;
  localparam logic [7:0] HEAD_E    = 8'hBF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERT   = 3'd1,
    VERT_W = 3'd2,
    HORZ   = 3'd3,
    HORZ_W = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  indx_nxt;
  logic        rdy_r, rdy_nxt;
  logic [15:0] vert_r, vert_nxt;
  logic [15:0] horz_r, horz_nxt;
  logic [7:0]  v_head, h_head;
  logic [3:0]  v_sq, h_sq;
  logic [15:0] v_dec, h_dec;

  // Lowest set bit wins; each leg is a heading plus a square count.
  always_comb begin
    v_head = HEAD_N;
    v_sq   = 4'd0;
    h_head = HEAD_E;
    h_sq   = 4'd0;
    casez (move)
      8'b???????1: begin v_head = HEAD_N; v_sq = 4'd2; h_head = HEAD_E; h_sq = 4'd1; end
      8'b??????10: begin v_head = HEAD_N; v_sq = 4'd2; h_head = HEAD_W; h_sq = 4'd1; end
      8'b?????100: begin v_head = HEAD_N; v_sq = 4'd1; h_head = HEAD_W; h_sq = 4'd2; end
      8'b????1000: begin v_head = HEAD_S; v_sq = 4'd1; h_head = HEAD_W; h_sq = 4'd2; end
      8'b???10000: begin v_head = HEAD_S; v_sq = 4'd2; h_head = HEAD_W; h_sq = 4'd1; end
      8'b??100000: begin v_head = HEAD_S; v_sq = 4'd2; h_head = HEAD_E; h_sq = 4'd1; end
      8'b?1000000: begin v_head = HEAD_S; v_sq = 4'd1; h_head = HEAD_E; h_sq = 4'd2; end
      8'b10000000: begin v_head = HEAD_N; v_sq = 4'd1; h_head = HEAD_E; h_sq = 4'd2; end
      default:     begin v_head = HEAD_N; v_sq = 4'd0; h_head = HEAD_E; h_sq = 4'd0; end
    endcase
  end

  assign v_dec = {OP_MOVE, v_head, v_sq};
  assign h_dec = {OP_FANFARE, h_head, h_sq};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= 5'd0;
      rdy_r   <= 1'b0;
      vert_r  <= 16'd0;
      horz_r  <= 16'd0;
    end else begin
      state   <= state_nxt;
      mv_indx <= indx_nxt;
      rdy_r   <= rdy_nxt;
      vert_r  <= vert_nxt;
      horz_r  <= horz_nxt;
    end
  end

  // In VERT/HORZ, rdy_r low marks the first cycle of the state: the leg is
  // captured (VERT) and cmd_rdy is raised on the following edge.
  always_comb begin
    state_nxt = state;
    indx_nxt  = mv_indx;
    rdy_nxt   = rdy_r;
    vert_nxt  = vert_r;
    horz_nxt  = horz_r;
    case (state)
      IDLE: begin
        rdy_nxt = 1'b0;
        if (start_tour) begin
          state_nxt = VERT;
          indx_nxt  = 5'd0;
        end
      end
      VERT: begin
        if (!rdy_r) begin
          if (move == 8'h00) begin
            state_nxt = IDLE;
            indx_nxt  = 5'd0;
          end else begin
            rdy_nxt  = 1'b1;
            vert_nxt = v_dec;
            horz_nxt = h_dec;
          end
        end else if (clr_cmd_rdy) begin
          state_nxt = VERT_W;
          rdy_nxt   = 1'b0;
        end
      end
      VERT_W: begin
        if (send_resp) state_nxt = HORZ;
      end
      HORZ: begin
        if (!rdy_r) begin
          rdy_nxt = 1'b1;
        end else if (clr_cmd_rdy) begin
          state_nxt = HORZ_W;
          rdy_nxt   = 1'b0;
        end
      end
      HORZ_W: begin
        if (send_resp) begin
          if (mv_indx == LAST_INDX) begin
            state_nxt = IDLE;
            indx_nxt  = 5'd0;
          end else begin
            state_nxt = VERT;
            indx_nxt  = mv_indx + 5'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        indx_nxt  = 5'd0;
        rdy_nxt   = 1'b0;
      end
    endcase
  end

  always_comb begin
    cmd     = cmd_UART;
    cmd_rdy = cmd_rdy_UART;
    case (state)
      IDLE:         begin cmd = cmd_UART; cmd_rdy = cmd_rdy_UART; end
      VERT:         begin cmd = rdy_r ? vert_r : v_dec; cmd_rdy = rdy_r; end
      VERT_W:       begin cmd = vert_r; cmd_rdy = rdy_r; end
      HORZ, HORZ_W: begin cmd = horz_r; cmd_rdy = rdy_r; end
      default:      begin cmd = cmd_UART; cmd_rdy = 1'b0; end
    endcase
  end

  assign resp = ((state == IDLE) ||
                 (state == HORZ_W && send_resp && mv_indx == LAST_INDX)) ? RESP_DONE : RESP_MID;

endmodule
`default_nettype wire

// File: tb/tb_tour_cmd.sv
`default_nettype none
// ============================================================================
// tb_tour_cmd : randomized bench for tour_cmd with a move-table reference model
// ============================================================================
module tb_tour_cmd;

  localparam logic [7:0] RESP_MID  = 8'h5A;
  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam int DX [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  localparam int DY [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  logic        clk = 1'b0;
  logic        rst_n, start_tour, cmd_rdy_UART, clr_cmd_rdy, send_resp;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART, cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;
  logic [7:0]  mv_tab [0:31];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  // TourLogic stand-in: move is combinational on the index
  assign move = mv_tab[mv_indx];

  tour_cmd dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .resp         (resp)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: knight displacement table -> robot leg command
  function automatic logic [15:0] leg(input logic [7:0] m, input bit horiz);
    int b;
    int d;
    int mag;
    b = -1;
    for (int i = 0; i < 8; i++) if (b < 0 && m[i]) b = i;
    if (b < 0) return 16'h0000;
    d   = horiz ? DX[b] : DY[b];
    mag = (d < 0) ? -d : d;
    if (horiz) return {4'h3, (d > 0) ? 8'hBF : 8'h3F, 4'(mag)};
    return {4'h2, (d > 0) ? 8'h00 : 8'h7F, 4'(mag)};
  endfunction

  task automatic pulse_start();
    @(negedge clk) start_tour = 1'b1;
    @(negedge clk) start_tour = 1'b0;
  endtask

  task automatic wait_rdy(output bit ok);
    int t;
    t = 0;
    while (cmd_rdy !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    ok = (cmd_rdy === 1'b1);
    if (!ok) chk("rdy_timeout", {15'd0, cmd_rdy}, 16'd1);
  endtask

  // Acts as cmd_proc for tour commands first_k .. first_k+ncmds-1
  task automatic serve(input int first_k, input int ncmds, input int maxd, input bit ends_tour);
    bit          ok;
    logic [15:0] e;
    for (int k = first_k; k < first_k + ncmds; k++) begin
      e = leg(mv_tab[k / 2], (k % 2) == 1);
      wait_rdy(ok);
      if (!ok) break;
      chk("cmd", cmd, e);
      chk("indx", {11'd0, mv_indx}, 16'(k / 2));
      chk("resp_mid", {8'd0, resp}, {8'd0, RESP_MID});
      repeat ($urandom_range(0, maxd)) @(negedge clk);
      chk("cmd_held", cmd, e);
      chk("rdy_held", {15'd0, cmd_rdy}, 16'd1);
      clr_cmd_rdy = 1'b1;
      start_tour  = 1'($urandom_range(0, 1));
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      start_tour  = 1'b0;
      chk("rdy_drop", {15'd0, cmd_rdy}, 16'd0);
      chk("cmd_wait", cmd, e);
      repeat ($urandom_range(0, maxd)) @(negedge clk);
      send_resp = 1'b1;
      #1;
      chk("resp_send", {8'd0, resp},
          {8'd0, (ends_tour && k == first_k + ncmds - 1) ? RESP_DONE : RESP_MID});
      @(negedge clk) send_resp = 1'b0;
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_indx", {11'd0, mv_indx}, 16'd0);
    chk("rst_rdy", {15'd0, cmd_rdy}, 16'd0);
    chk("rst_cmd", cmd, cmd_UART);
    chk("rst_resp", {8'd0, resp}, {8'd0, RESP_DONE});
  endtask

  task automatic rand_tour();
    for (int i = 0; i < 32; i++)
      mv_tab[i] = ($urandom_range(0, 1) == 1) ? 8'(1 << $urandom_range(0, 7))
                                              : 8'($urandom_range(1, 255));
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0; start_tour = 1'b0; cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0; cmd_UART = 16'h1234;
    for (int i = 0; i < 32; i++) mv_tab[i] = 8'h01;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    // UART passthrough
    cmd_UART = 16'h2BF3; cmd_rdy_UART = 1'b1;
    #1;
    chk("uart_cmd", cmd, 16'h2BF3);
    chk("uart_rdy", {15'd0, cmd_rdy}, 16'd1);
    chk("uart_resp", {8'd0, resp}, {8'd0, RESP_DONE});

    // Directed moves; UART inputs must be ignored during the tour
    mv_tab[0] = 8'h01; mv_tab[1] = 8'h08; mv_tab[2] = 8'h40;
    cmd_UART = 16'hFFFF;
    pulse_start();
    serve(0, 6, 2, 1'b0);
    chk("indx_after3", {11'd0, mv_indx}, 16'd3);
    cmd_rdy_UART = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    chk_reset_vals();

    // Full randomized tour
    rand_tour();
    cmd_UART = 16'($urandom); cmd_rdy_UART = 1'b1;
    pulse_start();
    serve(0, 48, 3, 1'b1);
    chk("end_indx", {11'd0, mv_indx}, 16'd0);
    chk("end_resp", {8'd0, resp}, {8'd0, RESP_DONE});
    chk("end_cmd", cmd, cmd_UART);
    chk("end_rdy", {15'd0, cmd_rdy}, 16'd1);
    cmd_rdy_UART = 1'b0;

    // Handshake hold, then reset while in HORZ_W of move 7
    rand_tour();
    pulse_start();
    serve(0, 2, 1, 1'b0);
    wait_rdy(ok);
    for (int c = 0; c < 50; c++) begin
      chk("hold_cmd", cmd, leg(mv_tab[1], 1'b0));
      chk("hold_rdy", {15'd0, cmd_rdy}, 16'd1);
      chk("hold_indx", {11'd0, mv_indx}, 16'd1);
      @(negedge clk);
    end
    serve(2, 13, 1, 1'b0);
    wait_rdy(ok);
    chk("m7_cmd", cmd, leg(mv_tab[7], 1'b1));
    clr_cmd_rdy = 1'b1;
    @(negedge clk) clr_cmd_rdy = 1'b0;
    chk("m7_indx", {11'd0, mv_indx}, 16'd7);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;

    // Empty move at tour start aborts to IDLE with no command issued
    mv_tab[0] = 8'h00;
    pulse_start();
    for (int c = 0; c < 6; c++) begin
      chk("abort_rdy", {15'd0, cmd_rdy}, 16'd0);
      @(negedge clk);
    end
    chk("abort_indx", {11'd0, mv_indx}, 16'd0);
    chk("abort_resp", {8'd0, resp}, {8'd0, RESP_DONE});
    cmd_UART = 16'h2BF3; cmd_rdy_UART = 1'b1;
    #1;
    chk("abort_uart", {15'd0, cmd_rdy}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
